// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=3, rate-1/2 (7/5 octal) code.
// Used by conv_encoder and viterbi_decoder.
package viterbi_pkg;

  localparam int unsigned NSTATES = 4;
  localparam int unsigned PM_INIT = 8;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] sym_t;
  typedef logic [1:0] state_t;

  // Expected code symbol {G0 out, G1 out} leaving {s1,s2} on input u.
  function automatic sym_t exp_sym(input state_t state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] ham2(input sym_t a, input sym_t b);
    sym_t x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Predecessor of next state {u,s1} whose oldest bit is s2.
  function automatic state_t pred_of(input state_t nxt, input logic s2);
    return {nxt[0], s2};
  endfunction

  // Information bit that leads into next state {u,s1}.
  function automatic logic in_bit(input state_t nxt);
    return nxt[1];
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// Transmit-side K=3 rate-1/2 convolutional encoder (generators 7/5).
// Optional SVA checks compile in when VITERBI_ASSERT_EN is defined.
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  state_t state;

  // Shift register and registered symbol; state only advances on enable_i.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= '0;
      valid_o <= 1'b0;
      d_out   <= '0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out <= exp_sym(state, d_in);
        state <= {d_in, state[1]};
      end
    end
  end

`ifdef VITERBI_ASSERT_EN
  a_valid_follows: assert property (@(posedge clk)
    $past(rst) |-> (valid_o == $past(enable_i)));
`endif

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder, K=3 rate-1/2 (7/5 octal).
// One symbol consumed and one bit emitted per enabled cycle; latency TB_DEPTH-1.
// Optional SVA checks compile in when VITERBI_ASSERT_EN is defined.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_RST = PM_W'(PM_INIT);

  logic [PM_W-1:0]     pm       [NSTATES];
  logic [TB_DEPTH-1:0] surv     [NSTATES];

  logic [PM_W-1:0]     cand0    [NSTATES];
  logic [PM_W-1:0]     cand1    [NSTATES];
  logic                sel      [NSTATES];
  logic [PM_W-1:0]     pm_acs   [NSTATES];
  logic [TB_DEPTH-1:0] surv_sel [NSTATES];
  logic [TB_DEPTH-1:0] surv_nxt [NSTATES];
  logic [PM_W-1:0]     pm_nxt   [NSTATES];
  logic [PM_W-1:0]     pm_min;
  state_t              best;

  // Saturating metric add; saturation only guards against wrap.
  function automatic logic [PM_W-1:0] add_sat(input logic [PM_W-1:0] a,
                                              input logic [1:0]      b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return (s > {1'b0, PM_MAX}) ? PM_MAX : s[PM_W-1:0];
  endfunction

  // Add-compare-select and register-exchange survivor update per next state.
  always_comb begin
    for (int unsigned ns = 0; ns < NSTATES; ns++) begin
      cand0[2'(ns)] = add_sat(pm[pred_of(2'(ns), 1'b0)],
                              ham2(d_in, exp_sym(pred_of(2'(ns), 1'b0), in_bit(2'(ns)))));
      cand1[2'(ns)] = add_sat(pm[pred_of(2'(ns), 1'b1)],
                              ham2(d_in, exp_sym(pred_of(2'(ns), 1'b1), in_bit(2'(ns)))));
      // Strict compare so a tie keeps the s2=0 predecessor.
      sel[2'(ns)]      = (cand1[2'(ns)] < cand0[2'(ns)]);
      pm_acs[2'(ns)]   = sel[2'(ns)] ? cand1[2'(ns)] : cand0[2'(ns)];
      surv_sel[2'(ns)] = sel[2'(ns)] ? surv[pred_of(2'(ns), 1'b1)]
                                     : surv[pred_of(2'(ns), 1'b0)];
      surv_nxt[2'(ns)] = {surv_sel[2'(ns)][TB_DEPTH-2:0], in_bit(2'(ns))};
    end
  end

  // Minimum metric, normalization and best-state pick (lowest index on tie).
  always_comb begin
    pm_min = PM_MAX;
    best   = '0;
    for (int unsigned ns = 0; ns < NSTATES; ns++) begin
      if (pm_acs[2'(ns)] < pm_min) begin
        pm_min = pm_acs[2'(ns)];
      end
      if (pm_acs[2'(ns)] < pm_acs[best]) begin
        best = 2'(ns);
      end
    end
    for (int unsigned ns = 0; ns < NSTATES; ns++) begin
      pm_nxt[2'(ns)] = pm_acs[2'(ns)] - pm_min;
    end
  end

  // Metric, survivor and output registers; everything holds while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NSTATES; s++) begin
        pm[2'(s)]   <= (s == 0) ? '0 : PM_RST;
        surv[2'(s)] <= '0;
      end
      d_out <= 1'b0;
    end else if (enable) begin
      for (int unsigned s = 0; s < NSTATES; s++) begin
        pm[2'(s)]   <= pm_nxt[2'(s)];
        surv[2'(s)] <= surv_nxt[2'(s)];
      end
      d_out <= surv_nxt[best][TB_DEPTH-1];
    end
  end

`ifdef VITERBI_ASSERT_EN
  a_norm_zero: assert property (@(posedge clk) disable iff (!rst)
    enable |-> (pm_nxt[best] == '0));
  a_no_sat: assert property (@(posedge clk) disable iff (!rst)
    enable |-> (pm_acs[0] != PM_MAX && pm_acs[1] != PM_MAX &&
                pm_acs[2] != PM_MAX && pm_acs[3] != PM_MAX));
  a_din_known: assert property (@(posedge clk) disable iff (!rst)
    enable |-> !$isunknown(d_in));
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Loopback bench: conv_encoder -> 1-cycle link register -> viterbi_decoder.
// Stimulus pushes expected encoder symbols and decoded bits into queues;
// a negedge monitor pops and compares whenever the DUTs present output.
module tb_viterbi_decoder;

  localparam int unsigned TB_DEPTH = 16;
  localparam int unsigned PM_W     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enc_en;
  logic       enc_bit;
  logic       enc_valid;
  logic [1:0] enc_sym;
  logic       link_en;
  logic [1:0] link_sym;
  logic       dec_out;
  logic       inject;
  int         link_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit         dq[$];
  logic [1:0] eq[$];
  bit         h1, h2;

  conv_encoder enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_en),
    .d_in     (enc_bit),
    .valid_o  (enc_valid),
    .d_out    (enc_sym)
  );

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (link_en),
    .d_in   (link_sym),
    .d_out  (dec_out)
  );

  logic [4*PM_W-1:0] cur_pm;
  assign cur_pm = {dut.pm[0], dut.pm[1], dut.pm[2], dut.pm[3]};

  // Channel: one register stage, optional 2-symbol burst on d_in[0] every 32.
  always @(posedge clk) begin
    if (!rst) begin
      link_en  <= 1'b0;
      link_sym <= 2'b00;
      link_cnt <= 0;
    end else begin
      link_en  <= enc_valid;
      link_sym <= enc_sym ^ {1'b0, (inject && enc_valid && link_cnt < 256 &&
                                    ((link_cnt % 32) == 10 || (link_cnt % 32) == 11))};
      if (enc_valid) link_cnt <= link_cnt + 1;
    end
  end

  // Reference encoder: parity of the tap window against octal generators 7 and 5.
  function automatic logic [1:0] ref_sym(input bit b, input bit p1, input bit p2);
    logic [2:0] taps;
    taps = {b, p1, p2};
    return {^(taps & 3'o7), ^(taps & 3'o5)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output seen with empty expectation queue at %0t", name, $time);
  endtask

  task automatic issue(input bit b, input logic [1:0] exp);
    eq.push_back(exp);
    dq.push_back(b);
    h2      = h1;
    h1      = b;
    enc_en  = 1'b1;
    enc_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rand();
    bit b;
    b = 1'($urandom);
    issue(b, ref_sym(b, h1, h2));
  endtask

  task automatic idle(input int n);
    enc_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset discards all history; decoder output lags by TB_DEPTH-1 zeros.
  task automatic do_reset(input int n);
    rst    = 1'b0;
    enc_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    eq.delete();
    dq.delete();
    for (int i = 0; i < int'(TB_DEPTH) - 1; i++) dq.push_back(1'b0);
    h1  = 1'b0;
    h2  = 1'b0;
    rst = 1'b1;
  endtask

  bit                rst_s = 1'b0;
  bit                en_s  = 1'b0;
  logic              last_out = 1'b0;
  logic [4*PM_W-1:0] last_pm  = '0;

  // Monitor: decides from the values the previous edge saw what must be visible now.
  always @(negedge clk) begin
    if (!rst_s) begin
      check("rst_dout", 32'(dec_out), 32'(1'b0));
      check("rst_pm", 32'(cur_pm), 32'({PM_W'(0), PM_W'(8), PM_W'(8), PM_W'(8)}));
      check("rst_enc", 32'({enc_valid, enc_sym}), 32'(3'b000));
    end else begin
      if (en_s) begin
        if (dq.size() == 0) underflow("dec_bit");
        else check("dec_bit", 32'(dec_out), 32'(dq.pop_front()));
      end else begin
        check("dec_hold", 32'({dec_out, cur_pm}), 32'({last_out, last_pm}));
      end
      if (enc_valid) begin
        if (eq.size() == 0) underflow("enc_sym");
        else check("enc_sym", 32'(enc_sym), 32'(eq.pop_front()));
      end
    end
    last_out = dec_out;
    last_pm  = cur_pm;
    rst_s    = rst;
    en_s     = link_en;
  end

  initial begin
    rst     = 1'b0;
    enc_en  = 1'b0;
    enc_bit = 1'b0;
    inject  = 1'b0;
    h1      = 1'b0;
    h2      = 1'b0;

    do_reset(3);

    // Known encoder vector, then clean random loopback with a 5-cycle gap.
    issue(1'b1, 2'b11);
    issue(1'b0, 2'b10);
    issue(1'b1, 2'b00);
    issue(1'b1, 2'b01);
    repeat (252) issue_rand();
    idle(5);
    repeat (40) issue_rand();

    // Burst errors on d_in[0] during the first 256 symbols after reset.
    do_reset(3);
    inject = 1'b1;
    repeat (280) issue_rand();
    inject = 1'b0;
    repeat (50) issue_rand();

    // Reset in the middle of traffic, then restart from state 0.
    do_reset(3);
    repeat (64) issue_rand();
    idle(4);

    check("enc_drain", 32'(eq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
